gray_binary_core: RTL and testbench

GRAY_BINARY_CORE -- requirements
Module: gray_binary

---
 rtl/gray_binary_core.sv | 121 ++++++++++++
 tb/tb_gray_binary_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gray_binary_core.sv
// -----------------------------------------------------------------------------
// gray_binary_core
//
// Binary-to-Gray converter with a one-stage capture register and a step
// monitor that flags when consecutive captured Gray codes differ in exactly
// one bit, plus a saturating count of such single-bit steps.
//
// Optional feature (compile-time macro):
//   GRAY_BINARY_DECODE_EN  - when defined, b_dec is the Gray-to-binary decode
//                            of g_q (equals the last captured b). When not
//                            defined, b_dec is tied to zero and no decode
//                            logic exists.
//
// Parameters:
//   WIDTH      code width in bits, legal range 2..32 (default 4)
//
// Ports:
//   clk        rising-edge clock for all registers
//   rst        asynchronous, active-high reset
//   b          binary input value
//   g          combinational Gray code of b (valid during reset)
//   in_valid   capture strobe: b is converted and registered this cycle
//   g_q        registered Gray code of the last captured b
//   out_valid  high for exactly the cycle after a capture
//   step_ok    last two captured Gray codes differ in exactly one bit
//   step_cnt   saturating count of captures that set step_ok
//   b_dec      binary decode of g_q, or zero without the decode feature
// -----------------------------------------------------------------------------
module gray_binary_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  input  logic             in_valid,
  output logic [WIDTH-1:0] g_q,
  output logic             out_valid,
  output logic             step_ok,
  output logic [15:0]      step_cnt,
  output logic [WIDTH-1:0] b_dec
);

  logic [WIDTH-1:0] g_d;
  logic             out_valid_q, out_valid_d;
  logic             step_ok_q, step_ok_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] step_diff;
  logic             single_bit;

  // Combinational conversion; depends only on b, so it stays live in reset.
  assign g = b ^ (b >> 1);

  // A non-zero value with exactly one bit set has no bits left after
  // clearing its lowest set bit.
  assign step_diff  = g ^ g_q;
  assign single_bit = (step_diff != '0) &&
                      ((step_diff & (step_diff - WIDTH'(1))) == '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    g_d         = g_q;
    out_valid_d = 1'b0;
    step_ok_d   = step_ok_q;
    step_cnt_d  = step_cnt_q;
    have_prev_d = have_prev_q;

    if (in_valid) begin
      g_d         = g;
      out_valid_d = 1'b1;
      have_prev_d = 1'b1;
      // The first capture after reset has nothing to compare against.
      step_ok_d   = have_prev_q && single_bit;
      if (step_ok_d && (step_cnt_q != 16'hFFFF)) begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q         <= '0;
      out_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_cnt_q  <= '0;
      have_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      step_ok_q   <= step_ok_d;
      step_cnt_q  <= step_cnt_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign out_valid = out_valid_q;
  assign step_ok   = step_ok_q;
  assign step_cnt  = step_cnt_q;

`ifdef GRAY_BINARY_DECODE_EN
  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  // Written as a per-bit reduction to avoid a self-referencing vector.
  logic [WIDTH-1:0] dec_bits;

  always_comb begin
    dec_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_bits[i] = ^(g_q >> i);
    end
  end

  assign b_dec = dec_bits;
`else
  assign b_dec = '0;
`endif

endmodule

// File: tb/tb_gray_binary_core.sv
// -----------------------------------------------------------------------------
// tb_gray_binary_core
//
// Directed self-checking bench for gray_binary_core (WIDTH = 4). Inputs are
// driven and outputs sampled 1 ns after each rising edge, away from the edge.
// Honours GRAY_BINARY_DECODE_EN for the expected b_dec value.
// -----------------------------------------------------------------------------
module tb_gray_binary_core;

  localparam int WIDTH = 4;

  // Hand-computed Gray codes for b = 0..15.
  localparam logic [3:0] GTAB [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;
  logic             in_valid;
  logic [WIDTH-1:0] g_q;
  logic             out_valid;
  logic             step_ok;
  logic [15:0]      step_cnt;
  logic [WIDTH-1:0] b_dec;

  int n_vec;
  int n_err;

  gray_binary_core #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .b         (b),
    .g         (g),
    .in_valid  (in_valid),
    .g_q       (g_q),
    .out_valid (out_valid),
    .step_ok   (step_ok),
    .step_cnt  (step_cnt),
    .b_dec     (b_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [3:0] val);
    b        = val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [3:0] dec_exp(input logic [3:0] bin);
`ifdef GRAY_BINARY_DECODE_EN
    return bin;
`else
    return 4'b0000;
`endif
  endfunction

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    b        = 4'b0101;
    in_valid = 1'b0;

    // Reset state, no clock edge yet; g stays live during reset.
    #2;
    check("rst_g_q",       32'(g_q),       32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_step_ok",   32'(step_ok),   32'h0);
    check("rst_step_cnt",  32'(step_cnt),  32'h0);
    check("rst_b_dec",     32'(b_dec),     32'h0);
    check("rst_g_live",    32'(g),         32'h7);

    tick();
    rst = 1'b0;

    // Combinational sweep with no captures.
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      #1;
      check($sformatf("comb_g_%0d", i), 32'(g), 32'(GTAB[i]));
    end
    tick();
    check("no_capture_g_q", 32'(g_q), 32'h0);
    check("no_capture_ov",  32'(out_valid), 32'h0);

    // Two back-to-back captures: 0101 -> 0111, 1111 -> 1000.
    b = 4'b0101; in_valid = 1'b1;
    tick();
    check("cap1_g_q",     32'(g_q),       32'h7);
    check("cap1_ov",      32'(out_valid), 32'h1);
    check("cap1_step_ok", 32'(step_ok),   32'h0);
    b = 4'b1111;
    tick();
    check("cap2_g_q",     32'(g_q),       32'h8);
    check("cap2_ov",      32'(out_valid), 32'h1);
    check("cap2_step_ok", 32'(step_ok),   32'h0);
    in_valid = 1'b0;
    tick();
    check("hold_g_q",     32'(g_q),       32'h8);
    check("hold_ov",      32'(out_valid), 32'h0);
    check("hold_step_cnt", 32'(step_cnt), 32'h0);

    // Sweep 0..15 then 0 from reset: every step after the first is one bit,
    // including the 1000 -> 0000 wrap.
    rst = 1'b1; #1; rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      capture(4'(k % 16));
      check($sformatf("sweep_g_q_%0d", k), 32'(g_q), 32'(GTAB[k % 16]));
      check($sformatf("sweep_ok_%0d", k), 32'(step_ok), (k == 0) ? 32'h0 : 32'h1);
      check($sformatf("sweep_cnt_%0d", k), 32'(step_cnt), 32'(k));
      check($sformatf("sweep_dec_%0d", k), 32'(b_dec), 32'(dec_exp(4'(k % 16))));
    end

    // Repeats and multi-bit steps (g_q is 0000, count 16 here).
    capture(4'b0011);  // 0000 -> 0010: one bit
    check("rep_a_ok",  32'(step_ok),  32'h1);
    check("rep_a_cnt", 32'(step_cnt), 32'd17);
    capture(4'b0011);  // identical: popcount 0
    check("rep_b_ok",  32'(step_ok),  32'h0);
    check("rep_b_cnt", 32'(step_cnt), 32'd17);
    capture(4'b0000);  // 0010 -> 0000: one bit
    check("rep_c_ok",  32'(step_ok),  32'h1);
    capture(4'b0011);  // 0000 -> 0010: one bit
    check("rep_d_ok",  32'(step_ok),  32'h1);
    check("rep_d_cnt", 32'(step_cnt), 32'd19);
    capture(4'b0000);  // 0010 -> 0000: one bit
    capture(4'b0101);  // 0000 -> 0111: three bits
    check("multi_ok",  32'(step_ok),  32'h0);
    check("multi_cnt", 32'(step_cnt), 32'd20);
    tick();            // no capture: step_ok holds
    check("multi_hold_ok", 32'(step_ok), 32'h0);

    // Asynchronous reset mid-stream after five captures.
    rst = 1'b1; #1; rst = 1'b0;
    for (int k = 0; k < 5; k++) capture(4'(k));
    check("pre_ar_g_q", 32'(g_q),      32'h6);
    check("pre_ar_cnt", 32'(step_cnt), 32'd4);
    b = 4'b1001; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("ar_g_q",     32'(g_q),       32'h0);
    check("ar_ov",      32'(out_valid), 32'h0);
    check("ar_step_ok", 32'(step_ok),   32'h0);
    check("ar_cnt",     32'(step_cnt),  32'h0);
    tick();            // capture attempt while in reset is discarded
    check("ar_discard_g_q", 32'(g_q),       32'h0);
    check("ar_discard_ov",  32'(out_valid), 32'h0);
    rst = 1'b0;
    b   = 4'b0111;
    tick();            // first capture after release
    in_valid = 1'b0;
    check("post_ar_g_q", 32'(g_q),      32'h4);
    check("post_ar_ok",  32'(step_ok),  32'h0);
    check("post_ar_cnt", 32'(step_cnt), 32'h0);

    // Decode of a captured value.
    capture(4'b1010);
    check("dec_1010", 32'(b_dec), 32'(dec_exp(4'b1010)));

    // Saturation: toggle b between 0 and 1 (one-bit Gray steps).
    rst = 1'b1; #1; rst = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 65536 + 4; k++) begin
      b = 4'(k & 1);
      tick();
      if (k == 65534) check("sat_pre_cnt", 32'(step_cnt), 32'hFFFE);
    end
    in_valid = 1'b0;
    check("sat_cnt", 32'(step_cnt), 32'hFFFF);
    check("sat_ok",  32'(step_ok),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
